// File: rtl/decode_issue_pkg.sv
// Shared opcode constants, immediate format selector and immediate generator
// for the decode/issue stage.
package decode_issue_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

    // Builds the 32-bit sign-extended immediate; the opcode bits are never needed.
    function automatic logic [31:0] imm_gen(input logic [31:7] instr, input imm_type_e kind);
        logic [31:0] imm;
        imm = '0;
        case (kind)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register busy scoreboard. A bit is set when EX accepts a writing
// instruction and cleared by its write-back. The pending vector also covers
// the instruction sitting in the issue register and hides a register whose
// write-back is happening this cycle.
module issue_scoreboard #(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_set_en,
    input  logic [REG_ADDR_W-1:0] i_set_idx,
    input  logic                  i_clr_en,
    input  logic [REG_ADDR_W-1:0] i_clr_idx,
    input  logic                  i_inflight_en,
    input  logic [REG_ADDR_W-1:0] i_inflight_idx,
    output logic [NUM_REGS-1:0]   o_pending
);

    logic [NUM_REGS-1:0] r_sb;
    logic [NUM_REGS-1:0] w_sb_next;

    // Next busy vector: clear is applied after set so it wins on a collision.
    always_comb begin
        w_sb_next = r_sb;
        if (i_set_en) begin
            w_sb_next[i_set_idx] = 1'b1;
        end
        if (i_clr_en) begin
            w_sb_next[i_clr_idx] = 1'b0;
        end
    end

    // Busy bit register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sb <= '0;
        end else begin
            r_sb <= w_sb_next;
        end
    end

    // Pending view used for hazard detection.
    always_comb begin
        o_pending = '0;
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            o_pending[r] = (r_sb[r] |
                            (i_inflight_en & (i_inflight_idx == REG_ADDR_W'(r)))) &
                           ~(i_clr_en & (i_clr_idx == REG_ADDR_W'(r)));
        end
    end

endmodule

// File: rtl/decode_issue_stage.sv
// RV32I decode and issue stage: decodes the fetched word, reads operands from
// the local register file (with write-back bypass), stalls on RAW/WAW hazards
// via the scoreboard and holds the decoded instruction in an issue register.
module decode_issue_stage
    import decode_issue_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [XLEN-1:0]       in_pc,
    input  logic                  flush,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [XLEN-1:0]       out_rs1_val,
    output logic [XLEN-1:0]       out_rs2_val,
    output logic [XLEN-1:0]       out_imm,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_rd_we,
    output logic [6:0]            out_opcode,
    output logic [2:0]            out_funct3,
    output logic                  out_funct7b5,
    output logic                  out_illegal,
    output logic [31:0]           stall_cycles
);

    // Decode wires
    logic [6:0]            w_opcode;
    logic [4:0]            w_rs1_full, w_rs2_full, w_rd_full;
    logic [REG_ADDR_W-1:0] w_rs1, w_rs2, w_rd;
    imm_type_e             w_imm_type;
    logic                  w_known, w_writes_rd, w_uses_rs1, w_uses_rs2;
    logic                  w_illegal, w_rd_we;
    logic [XLEN-1:0]       w_imm, w_rs1_val, w_rs2_val;
    logic [NUM_REGS-1:0]   w_pending;
    logic                  w_hazard, w_accept, w_sb_set;

    // Architectural state and issue register
    logic [XLEN-1:0]       r_regs [NUM_REGS];
    logic                  r_out_valid;
    logic [XLEN-1:0]       r_out_pc, r_out_rs1_val, r_out_rs2_val, r_out_imm;
    logic [REG_ADDR_W-1:0] r_out_rd;
    logic                  r_out_rd_we, r_out_funct7b5, r_out_illegal;
    logic [6:0]            r_out_opcode;
    logic [2:0]            r_out_funct3;
    logic [31:0]           r_stall_cycles;

    assign w_opcode   = in_instr[6:0];
    assign w_rd_full  = in_instr[11:7];
    assign w_rs1_full = in_instr[19:15];
    assign w_rs2_full = in_instr[24:20];
    assign w_rd       = w_rd_full[REG_ADDR_W-1:0];
    assign w_rs1      = w_rs1_full[REG_ADDR_W-1:0];
    assign w_rs2      = w_rs2_full[REG_ADDR_W-1:0];

    // Opcode classification: immediate format and register usage.
    always_comb begin
        w_imm_type  = IMM_NONE;
        w_known     = 1'b0;
        w_writes_rd = 1'b0;
        w_uses_rs1  = 1'b0;
        w_uses_rs2  = 1'b0;
        case (w_opcode)
            OP: begin
                w_known = 1'b1; w_writes_rd = 1'b1; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
            end
            OP_IMM, LOAD, JALR: begin
                w_imm_type = IMM_I;
                w_known = 1'b1; w_writes_rd = 1'b1; w_uses_rs1 = 1'b1;
            end
            STORE: begin
                w_imm_type = IMM_S;
                w_known = 1'b1; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
            end
            BRANCH: begin
                w_imm_type = IMM_B;
                w_known = 1'b1; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
            end
            LUI, AUIPC: begin
                w_imm_type = IMM_U;
                w_known = 1'b1; w_writes_rd = 1'b1;
            end
            JAL: begin
                w_imm_type = IMM_J;
                w_known = 1'b1; w_writes_rd = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_imm = XLEN'($signed(imm_gen(in_instr[31:7], w_imm_type)));

    // Only indices the instruction actually uses can make it illegal.
    assign w_illegal = ~w_known |
                       (w_uses_rs1  & (32'(w_rs1_full) >= NUM_REGS)) |
                       (w_uses_rs2  & (32'(w_rs2_full) >= NUM_REGS)) |
                       (w_writes_rd & (32'(w_rd_full)  >= NUM_REGS));
    assign w_rd_we   = w_writes_rd & ~w_illegal & (w_rd != '0);

    // Operand read with x0 hardwired and write-back bypass.
    always_comb begin
        w_rs1_val = r_regs[w_rs1];
        w_rs2_val = r_regs[w_rs2];
        if (w_rs1 == '0) begin
            w_rs1_val = '0;
        end else if (wb_en && (wb_rd == w_rs1)) begin
            w_rs1_val = wb_data;
        end
        if (w_rs2 == '0) begin
            w_rs2_val = '0;
        end else if (wb_en && (wb_rd == w_rs2)) begin
            w_rs2_val = wb_data;
        end
    end

    // A flushed issue-register entry never reaches EX, so it must not mark rd busy.
    assign w_sb_set = r_out_valid & out_ready & r_out_rd_we & ~flush;

    issue_scoreboard #(
        .NUM_REGS   (NUM_REGS),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_scoreboard (
        .clock          (clock),
        .reset          (reset),
        .i_set_en       (w_sb_set),
        .i_set_idx      (r_out_rd),
        .i_clr_en       (wb_en),
        .i_clr_idx      (wb_rd),
        .i_inflight_en  (r_out_valid & r_out_rd_we),
        .i_inflight_idx (r_out_rd),
        .o_pending      (w_pending)
    );

    // Illegal instructions skip the hazard check and issue immediately.
    assign w_hazard = in_valid & ~w_illegal &
                      ((w_uses_rs1 & w_pending[w_rs1]) |
                       (w_uses_rs2 & w_pending[w_rs2]) |
                       (w_rd_we    & w_pending[w_rd]));
    assign in_ready = ~w_hazard & (~r_out_valid | out_ready) & ~flush;
    assign w_accept = in_valid & in_ready;

    // Register file write port; x0 is never written.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en && (wb_rd != '0)) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    // Issue register: flush kills, accept loads, EX handshake drains.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid    <= 1'b0;
            r_out_pc       <= '0;
            r_out_rs1_val  <= '0;
            r_out_rs2_val  <= '0;
            r_out_imm      <= '0;
            r_out_rd       <= '0;
            r_out_rd_we    <= 1'b0;
            r_out_opcode   <= '0;
            r_out_funct3   <= '0;
            r_out_funct7b5 <= 1'b0;
            r_out_illegal  <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid    <= 1'b1;
            r_out_pc       <= in_pc;
            r_out_rs1_val  <= w_rs1_val;
            r_out_rs2_val  <= w_rs2_val;
            r_out_imm      <= w_imm;
            r_out_rd       <= w_rd;
            r_out_rd_we    <= w_rd_we;
            r_out_opcode   <= w_opcode;
            r_out_funct3   <= in_instr[14:12];
            r_out_funct7b5 <= in_instr[30];
            r_out_illegal  <= w_illegal;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Hazard stall counter; back-pressure and flush cycles are not counted.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (in_valid && w_hazard && !flush) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_pc       = r_out_pc;
    assign out_rs1_val  = r_out_rs1_val;
    assign out_rs2_val  = r_out_rs2_val;
    assign out_imm      = r_out_imm;
    assign out_rd       = r_out_rd;
    assign out_rd_we    = r_out_rd_we;
    assign out_opcode   = r_out_opcode;
    assign out_funct3   = r_out_funct3;
    assign out_funct7b5 = r_out_funct7b5;
    assign out_illegal  = r_out_illegal;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Parametrised successor to the 5-stage core's decode stage.
- Decodes RV32I instructions and reads operands from an internal register file with write-back bypass.
- Replaces the forwarding mux with a per-register scoreboard that stalls on RAW/WAW hazards.
- Sits between fetch and execute with valid/ready handshakes on both sides, and supports a redirect flush and a stall performance counter.

Parameters:
- XLEN, 32, data/PC width.
- NUM_REGS, 32, architectural registers (16 gives RV32E).
- REG_ADDR_W, 5, register index width; must equal clog2(NUM_REGS) (4 when NUM_REGS=16).

Ports:
- clock  in  1  core clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  fetch holds an instruction.
- in_ready  out  1  stage accepts it this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- flush  in  1  redirect from EX; kill the held and incoming instruction.
- wb_en  in  1  write-back valid.
- wb_rd  in  REG_ADDR_W  write-back register.
- wb_data  in  XLEN  write-back value.
- out_valid  out  1  issue register holds an instruction.
- out_ready  in  1  EX accepts it.
- out_pc  out  XLEN  PC of the issued instruction.
- out_rs1_val, out_rs2_val  out  XLEN  operands.
- out_imm  out  XLEN  sign-extended immediate.
- out_rd  out  REG_ADDR_W  destination register.
- out_rd_we  out  1  instruction writes rd.
- out_opcode  out  7  opcode.
- out_funct3  out  3  funct3.
- out_funct7b5  out  1  instr[30].
- out_illegal  out  1  unknown opcode, or register index >= NUM_REGS.
- stall_cycles  out  32  hazard-stall count.

Behaviour:
- Reset (synchronous, active-high): out_valid=0; all scoreboard bits=0; all registers=0; stall_cycles=0; other out_* =0.
- Decode:
  - rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7], truncated to REG_ADDR_W.
  - Immediate format chosen by opcode: I (OP-IMM, LOAD, JALR), S (STORE), B (BRANCH), U (LUI, AUIPC), J (JAL); 0 otherwise.
  - rd_we=1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, forced to 0 when rd==0.
  - uses_rs1 for OP, OP-IMM, LOAD, STORE, BRANCH, JALR; uses_rs2 for OP, STORE, BRANCH.
- Illegal: out_illegal=1 for any other opcode, or when a used index's discarded upper bits are non-zero. An illegal instruction still issues, with rd_we=0 and no hazard check.
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - Write on wb_en at the clock edge.
  - Read bypass: if wb_en && wb_rd==rsN && rsN!=0, the operand is wb_data.
- Pending per register r: sb[r] | (out_valid & out_rd_we & out_rd==r), masked by ~(wb_en & wb_rd==r).
- Hazard: in_valid & ((uses_rs1 & pending[rs1]) | (uses_rs2 & pending[rs2]) | (rd_we & pending[rd])).
- Handshake:
  - in_ready = ~hazard & (~out_valid | out_ready) & ~flush.
  - On in_valid & in_ready: latch all out_* fields and set out_valid=1.
  - On out_valid & out_ready & ~(in_valid & in_ready): clear out_valid.
  - out_* are stable while out_valid & ~out_ready.
- Scoreboard:
  - Set sb[out_rd] on out_valid & out_ready & out_rd_we.
  - Clear sb[wb_rd] on wb_en.
  - Same-cycle set and clear of one register cannot occur, because WAW stalls. Clear wins if it does.
- Flush (highest priority):
  - Next cycle out_valid=0; in_ready=0 in the flush cycle.
  - sb is unchanged: instructions already accepted by EX still write back.
  - A write-back in the flush cycle still updates the register file and sb.
- Latency: one cycle from input handshake to out_valid; zero-bubble back-to-back issue when no hazard.
- stall_cycles: increments on in_valid & hazard & ~flush; wraps at 2^32.
- Reset mid-operation: the next cycle matches the reset state, dropping in-flight issue and pending bits.

Decomposition:
- Package decode_issue_pkg: opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC), imm_type_e enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE}.
- Sub-module issue_scoreboard (NUM_REGS, REG_ADDR_W): set/clear ports, pending vector output.

Test Plan:
- Reset, then `addi x1,x0,5` (0x00500093) with out_ready=1 -> next cycle out_valid=1, out_imm=5, out_rd=1, out_rd_we=1; sb[1]=1 after the EX handshake.
- `addi x1`, then `add x2,x1,x1` with no write-back -> in_ready=0 and stall_cycles increments each cycle. Then wb_en=1, wb_rd=1, wb_data=5 -> the add issues that cycle with rs1_val=rs2_val=5.
- out_ready=0 for 3 cycles with in_valid=1 -> out_* held constant, in_ready=0, stall_cycles unchanged.
- flush while out_valid=1 and in_valid=1 -> next cycle out_valid=0, the incoming instruction is dropped, sb bits unchanged.
- `beq x3,x4,-8` (0xFE418CE3) -> out_imm=0xFFFFFFF8, out_rd_we=0; `jal x0,+2048` -> out_rd_we=0, imm=0x800.
- NUM_REGS=16: `addi x17,x0,1` -> out_illegal=1, out_rd_we=0, issues without stall; opcode 0x7F -> out_illegal=1.
